// File: rtl/pc_fetch_control_pkg.sv
// Shared CPU definitions for the fetch stage and the instruction MMU.
//   ADDR_W      : width of the word-addressed logical instruction address
//   BOOT_ADDR   : PC value after reset
//   INT_VECTOR  : kernel handler entry loaded after interrupt acknowledge
//   fetch_state_t : controller state encoding (RUN / ACK / HALTED)
//   mode_t        : kernel/user mode encoding seen by the MMU
package cpu_defs;

    localparam int ADDR_W = 26;

    localparam logic [ADDR_W-1:0] BOOT_ADDR  = '0;
    localparam logic [ADDR_W-1:0] INT_VECTOR = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ACK    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    // inta forces the MMU into kernel mode.
    typedef enum logic {
        MODE_USER   = 1'b0,
        MODE_KERNEL = 1'b1
    } mode_t;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);   // wraps modulo 2^ADDR_W
    endfunction

endpackage

// File: rtl/pc_fetch_control_if.sv
// Bundle of redirect/control inputs and fetch outputs of pc_fetch_control.
//   slave  : pc_fetch_control side (receives control, drives pc/inta/epc)
//   master : upstream pipeline / interrupt side
interface pc_fetch_control_if;
    import cpu_defs::*;

    logic              stall;
    logic              halt;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              jr;
    logic [ADDR_W-1:0] jr_target;
    logic              eret;
    logic              irq;
    logic              irq_en;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              fetch_valid;
    logic              inta;
    logic [ADDR_W-1:0] epc;
    logic              in_service;

    modport slave (
        input  stall, halt, branch_taken, branch_target, jump, jump_target,
               jr, jr_target, eret, irq, irq_en,
        output pc, pc_plus1, fetch_valid, inta, epc, in_service
    );

    modport master (
        output stall, halt, branch_taken, branch_target, jump, jump_target,
               jr, jr_target, eret, irq, irq_en,
        input  pc, pc_plus1, fetch_valid, inta, epc, in_service
    );
endinterface

// File: rtl/pc_fetch_control_pc_next_mux.sv
// Combinational priority select of the next sequential-or-redirect PC.
// Priority: eret > jr > jump > branch_taken > pc+1 (halt also yields pc+1).
//   i_pc_plus1 / i_epc / i_*_target : candidate addresses
//   i_eret / i_jr / i_jump / i_branch_taken : redirect requests
//   o_next_pc : selected address
//   o_redirect : any redirect (non-sequential) selected
module pc_next_mux
    import cpu_defs::*;
(
    input  logic [ADDR_W-1:0] i_pc_plus1,
    input  logic [ADDR_W-1:0] i_epc,
    input  logic              i_eret,
    input  logic              i_jr,
    input  logic [ADDR_W-1:0] i_jr_target,
    input  logic              i_jump,
    input  logic [ADDR_W-1:0] i_jump_target,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_redirect
);

    always_comb begin
        o_next_pc  = i_pc_plus1;
        o_redirect = 1'b1;
        if (i_eret)              o_next_pc = i_epc;
        else if (i_jr)           o_next_pc = i_jr_target;
        else if (i_jump)         o_next_pc = i_jump_target;
        else if (i_branch_taken) o_next_pc = i_branch_target;
        else                     o_redirect = 1'b0;
    end

endmodule

// File: rtl/pc_fetch_control.sv
// Program counter and fetch control upstream of the instruction MMU.
// Arbitrates sequential/branch/jump/jr/eret flow, interrupt entry and
// halt/wake; saves the interrupted return address in EPC.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : pc_fetch_control_if.slave (controls in; pc, pc_plus1,
//              fetch_valid, inta, epc, in_service out)
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | fetching and executing; fetch_valid=1
// ACK     | one-cycle interrupt acknowledge; inta=1, pc held
// HALTED  | HALT executed; pc held until an interrupt is accepted
module pc_fetch_control
    import cpu_defs::*;
#(
    parameter logic [ADDR_W-1:0] P_BOOT_ADDR  = BOOT_ADDR,
    parameter logic [ADDR_W-1:0] P_INT_VECTOR = INT_VECTOR
) (
    input  logic               clk,
    input  logic               rst,
    pc_fetch_control_if.slave  bus
);

    fetch_state_t      r_state, w_state_d;
    logic [ADDR_W-1:0] r_pc, w_pc_d;
    logic [ADDR_W-1:0] r_epc, w_epc_d;
    logic              r_in_service, w_in_service_d;
    logic              r_inta;

    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_redirect;
    logic              w_accept;

    assign w_pc_plus1 = addr_inc(r_pc);

    // eret is excluded so a simultaneous eret always completes first.
    assign w_accept = bus.irq & bus.irq_en & ~r_in_service & ~bus.stall & ~bus.eret;

    pc_next_mux u_pc_next_mux (
        .i_pc_plus1      (w_pc_plus1),
        .i_epc           (r_epc),
        .i_eret          (bus.eret),
        .i_jr            (bus.jr),
        .i_jr_target     (bus.jr_target),
        .i_jump          (bus.jump),
        .i_jump_target   (bus.jump_target),
        .i_branch_taken  (bus.branch_taken),
        .i_branch_target (bus.branch_target),
        .o_next_pc       (w_next_pc),
        .o_redirect      (w_redirect)
    );

    always_comb begin
        w_state_d      = r_state;
        w_pc_d         = r_pc;
        w_epc_d        = r_epc;
        w_in_service_d = r_in_service;
        unique case (r_state)
            ST_RUN: begin
                if (bus.stall) begin
                    // hold everything
                end else if (w_accept) begin
                    // pc is held; the interrupted instruction's successor is saved
                    w_epc_d   = w_next_pc;
                    w_state_d = ST_ACK;
                end else begin
                    w_pc_d = w_next_pc;
                    if (bus.eret)
                        w_in_service_d = 1'b0;
                    if (bus.halt && !w_redirect)
                        w_state_d = ST_HALTED;
                end
            end
            ST_ACK: begin
                w_pc_d         = P_INT_VECTOR;
                w_in_service_d = 1'b1;
                w_state_d      = ST_RUN;
            end
            ST_HALTED: begin
                if (w_accept) begin
                    w_epc_d   = r_pc;
                    w_state_d = ST_ACK;
                end
            end
            default: w_state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= P_BOOT_ADDR;
            r_epc        <= '0;
            r_in_service <= 1'b0;
            r_inta       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_pc         <= w_pc_d;
            r_epc        <= w_epc_d;
            r_in_service <= w_in_service_d;
            r_inta       <= (w_state_d == ST_ACK);
        end
    end

    assign bus.pc          = r_pc;
    assign bus.pc_plus1    = w_pc_plus1;
    assign bus.fetch_valid = (r_state == ST_RUN);
    assign bus.inta        = r_inta;
    assign bus.epc         = r_epc;
    assign bus.in_service  = r_in_service;

endmodule

// File: doc/pc_fetch_control.md
Name: pc_fetch_control

Overview:
Program-counter and fetch-control stage directly upstream of the instruction-memory MMU. It produces the logical instruction address (the MMU's logical-address input) and the interrupt-acknowledge pulse that forces the MMU into kernel mode. It arbitrates sequential, branch, jump, register-jump, exception-return and interrupt redirection, and implements halt/wake sequencing. It saves the interrupted return address in an EPC register.

Parameters:
ADDR_W, 26, width of word-addressed logical instruction address
BOOT_ADDR, 0, PC value after reset
INT_VECTOR, 1, PC loaded after interrupt acknowledge (kernel handler entry)

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
stall  in  1  hold PC (memory/hazard stall); defers interrupt acceptance
halt  in  1  current instruction is HALT
branch_taken  in  1  conditional branch resolved taken
branch_target  in  ADDR_W  branch destination
jump  in  1  J/JAL
jump_target  in  ADDR_W  jump destination
jr  in  1  JR/JALR
jr_target  in  ADDR_W  register-jump destination
eret  in  1  return from interrupt
irq  in  1  level interrupt request (timer/IO)
irq_en  in  1  global interrupt enable (kernel-controlled)
pc  out  ADDR_W  logical fetch address to MMU
pc_plus1  out  ADDR_W  pc+1 (link value for JAL)
fetch_valid  out  1  fetched word at pc is to be executed
inta  out  1  interrupt acknowledge to MMU/interrupt controller
epc  out  ADDR_W  saved return address
in_service  out  1  interrupt handler active (nesting masked)

Behaviour:
- Reset (rst=1 at edge): pc=BOOT_ADDR, epc=0, inta=0, in_service=0, state=RUN; rst overrides every other input.
- States: RUN, ACK, HALTED. fetch_valid=1 only in RUN.
- Accept condition: irq & irq_en & ~in_service & ~stall & ~eret, evaluated in RUN or HALTED.
- RUN, priority at each edge:
  - stall: hold pc and state. Interrupt is not accepted.
  - accept: state->ACK; epc<=next PC the current instruction would have produced (redirect target or pc+1; pc+1 if halt); pc held.
  - eret: pc<=epc, in_service<=0.
  - jr: pc<=jr_target.
  - jump: pc<=jump_target.
  - branch_taken: pc<=branch_target.
  - halt: pc<=pc+1, state->HALTED.
  - otherwise: pc<=pc+1.
- ACK: lasts exactly one cycle. inta=1 (registered; high only in ACK). Inputs ignored except rst. Next edge: pc<=INT_VECTOR, in_service<=1, state->RUN. The MMU sees inta during ACK, so the first vector fetch is already in kernel mode.
- HALTED: pc held, inputs other than irq-accept and rst ignored. On accept: epc<=pc, state->ACK. No wake without an accepted interrupt.
- Arithmetic: pc+1 modulo 2^ADDR_W; max address wraps to 0 with no flag.
- Simultaneous events:
  - eret with irq: eret wins, and the interrupt may be accepted the following cycle.
  - irq held during in_service: ignored until eret completes.
  - irq deasserted before accept: nothing happens (level, not latched).
- Reset mid-ACK or in HALTED: immediate return to reset values, no inta afterward.

Decomposition:
- Shared package (cpu_defs): ADDR_W, BOOT_ADDR, INT_VECTOR, state encoding localparams (RUN/ACK/HALTED), kernel/user mode encoding shared with the MMU.
- One natural sub-module: pc_next_mux (combinational priority select of the next PC from redirect inputs). Controller FSM, EPC, and PC registers live at top level.

Test Plan:
- Reset then 3 free cycles -> pc 0,1,2,3; fetch_valid=1; inta=0.
- At pc=5: branch_taken=1, target=40, with jump=1, jump_target=80 in the same cycle -> pc=80 (jump beats branch); next cycle jr=1, jr_target=7 -> pc=7.
- irq=1, irq_en=1 at pc=10, no redirect -> next cycle inta=1, fetch_valid=0, epc=11, pc=10; following cycle pc=1 (INT_VECTOR), in_service=1, inta=0.
- In handler: irq held -> no second inta; eret=1 -> pc=11, in_service=0; irq still high -> inta one cycle later.
- stall=1 for 4 cycles with irq pending -> pc frozen, inta=0 throughout; inta on cycle after stall drops.
- halt at pc=20 -> pc=21, fetch_valid=0 indefinitely; irq with irq_en=0 -> stays halted; irq_en=1 -> ACK, epc=21, then pc=1. Also assert rst during ACK -> pc=0, inta=0 next cycle.
